// File: rtl/kernel_mul_rr_sched.sv
// kernel_mul_rr_sched: round-robin scheduler sharing one external 31x32
// unsigned multiplier among NUM_REQ requesters, with a one-deep tagged
// response register on a valid/ready channel.
// Optional build macro: KERNEL_MUL_RR_SCHED_STATS_EN adds a saturating
// stall_cnt output counting cycles where a response waits on rsp_ready.
module kernel_mul_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*31-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [30:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [61:0]          mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
`ifdef KERNEL_MUL_RR_SCHED_STATS_EN
  output logic [31:0]          stall_cnt,
`endif
  output logic [61:0]          rsp_p
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            can_issue;
  logic            grant_vld;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nxt;
  logic [ID_W-1:0] idx;
  int              sum;

  assign rsp_valid = (state == FULL);

  // Response-register occupancy state, cleared by synchronous reset.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Issue is allowed when the register is empty or being drained this cycle.
  always_comb begin
    can_issue = 1'b0;
    state_nxt = state;
    if (ap_rst_n && ((state == EMPTY) || rsp_ready)) begin
      can_issue = 1'b1;
    end
    if (grant_vld) begin
      state_nxt = FULL;
    end else if ((state == FULL) && rsp_ready) begin
      state_nxt = EMPTY;
    end
  end

  // Round-robin search starting at ptr, ascending and wrapping at NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    sum       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      idx = ID_W'(sum);
      if (can_issue && !grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = idx;
      end
    end
  end

  // Grant steering: one-hot ready and operand mux, all zero when idle.
  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    ptr_nxt   = ptr;
    if (grant_vld) begin
      req_ready[grant_id] = 1'b1;
      mul_a   = req_a[int'(grant_id)*31 +: 31];
      mul_b   = req_b[int'(grant_id)*32 +: 32];
      ptr_nxt = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Capture product and tag on grant; hold them otherwise.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rsp_p  <= '0;
      rsp_id <= '0;
      ptr    <= '0;
    end else if (grant_vld) begin
      rsp_p  <= mul_p;
      rsp_id <= grant_id;
      ptr    <= ptr_nxt;
    end
  end

`ifdef KERNEL_MUL_RR_SCHED_STATS_EN
  // Saturating count of cycles a valid response is back-pressured.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      stall_cnt <= '0;
    end else if (rsp_valid && !rsp_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kernel_mul_rr_sched.sv
// Directed testbench for kernel_mul_rr_sched with a response scoreboard.
module tb_kernel_mul_rr_sched;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  ap_clk = 1'b0;
  logic                  ap_rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*31-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [30:0]           mul_a;
  logic [31:0]           mul_b;
  logic [61:0]           mul_p;
  logic [62:0]           mul_full;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [61:0]           rsp_p;
`ifdef KERNEL_MUL_RR_SCHED_STATS_EN
  logic [31:0]           stall_cnt;
`endif

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [61:0]     p;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  logic [30:0] opA  [NUM_REQ];
  logic [31:0] opB  [NUM_REQ];
  logic [61:0] prodC[NUM_REQ];

  kernel_mul_rr_sched #(.NUM_REQ(NUM_REQ)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
`ifdef KERNEL_MUL_RR_SCHED_STATS_EN
    .stall_cnt (stall_cnt),
`endif
    .rsp_p     (rsp_p)
  );

  always #5 ap_clk = ~ap_clk;

  // Shared multiplier stand-in: full product truncated to 62 bits.
  assign mul_full = {32'b0, mul_a} * {31'b0, mul_b};
  assign mul_p    = mul_full[61:0];

  // Pop and compare one expected result per response handshake.
  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      tests++;
      assert (sb.size() > 0) else begin
        fails++;
        $error("[TB] FAIL sb_underflow observed=%0d expected=>0", sb.size());
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        assert (rsp_id === e.id) else begin
          fails++;
          $error("[TB] FAIL rsp_id observed=%0d expected=%0d", rsp_id, e.id);
        end
        tests++;
        assert (rsp_p === e.p) else begin
          fails++;
          $error("[TB] FAIL rsp_p observed=%0h expected=%0h", rsp_p, e.p);
        end
      end
    end
  end

  task automatic applyStimulus(input logic rstn, input logic [NUM_REQ-1:0] v, input logic r);
    @(posedge ap_clk);
    #1;
    ap_rst_n  = rstn;
    req_valid = v;
    rsp_ready = r;
    @(negedge ap_clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expectGrant(input int id);
    exp_t e;
    e.id = ID_W'(id);
    e.p  = prodC[id];
    sb.push_back(e);
  endtask

  initial begin
    opA[0] = 31'd3;          opB[0] = 32'd5;          prodC[0] = 62'd15;
    opA[1] = 31'd6;          opB[1] = 32'd7;          prodC[1] = 62'd42;
    opA[2] = 31'h7FFF_FFFF;  opB[2] = 32'hFFFF_FFFF;  prodC[2] = 62'h3FFF_FFFE_8000_0001;
    opA[3] = 31'd100;        opB[3] = 32'd200;        prodC[3] = 62'd20000;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[31*i +: 31] = opA[i];
      req_b[32*i +: 32] = opB[i];
    end
    ap_rst_n  = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;

    // Reset held with requests pending: nothing granted, outputs quiet.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 4'hF, 1'b1);
      checkOutput("rst_req_ready", 64'(req_ready), 64'h0);
      checkOutput("rst_mul_a", 64'(mul_a), 64'h0);
      checkOutput("rst_mul_b", 64'(mul_b), 64'h0);
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    end
    checkOutput("rst_rsp_id", 64'(rsp_id), 64'h0);
    checkOutput("rst_rsp_p", 64'(rsp_p), 64'h0);
`ifdef KERNEL_MUL_RR_SCHED_STATS_EN
    checkOutput("rst_stall_cnt", 64'(stall_cnt), 64'h0);
`endif

    // Released but idle.
    applyStimulus(1'b1, 4'h0, 1'b1);
    checkOutput("idle_req_ready", 64'(req_ready), 64'h0);
    checkOutput("idle_mul_a", 64'(mul_a), 64'h0);
    checkOutput("idle_rsp_valid", 64'(rsp_valid), 64'h0);

    // All valid: grants rotate 0,1,2,3,0 at one per cycle.
    for (int k = 0; k < 5; k++) begin
      int id;
      id = k % NUM_REQ;
      applyStimulus(1'b1, 4'hF, 1'b1);
      checkOutput("rr_req_ready", 64'(req_ready), 64'(1 << id));
      checkOutput("rr_mul_a", 64'(mul_a), 64'(opA[id]));
      checkOutput("rr_mul_b", 64'(mul_b), 64'(opB[id]));
      if (k > 0) checkOutput("rr_rsp_valid", 64'(rsp_valid), 64'h1);
      expectGrant(id);
    end

    // Requester 2 alone with the widest operands (ptr=1, search reaches 2).
    applyStimulus(1'b1, 4'b0100, 1'b1);
    checkOutput("max_req_ready", 64'(req_ready), 64'b0100);
    expectGrant(2);
    applyStimulus(1'b1, 4'h0, 1'b1);
    checkOutput("max_rsp_valid", 64'(rsp_valid), 64'h1);
    checkOutput("max_rsp_p", 64'(rsp_p), 64'h3FFF_FFFE_8000_0001);

    // ptr=3: requesters 1 and 3 valid -> 3 first, then wrap to 1.
    applyStimulus(1'b1, 4'b1010, 1'b1);
    checkOutput("wrap_first", 64'(req_ready), 64'b1000);
    expectGrant(3);
    applyStimulus(1'b1, 4'b1010, 1'b1);
    checkOutput("wrap_second", 64'(req_ready), 64'b0010);
    expectGrant(1);
    applyStimulus(1'b1, 4'h0, 1'b1);
    checkOutput("wrap_drain_valid", 64'(rsp_valid), 64'h1);
    applyStimulus(1'b1, 4'h0, 1'b1);
    checkOutput("wrap_empty", 64'(rsp_valid), 64'h0);

    // Back-pressure: one grant into empty register, then five held cycles.
    applyStimulus(1'b1, 4'hF, 1'b0);
    checkOutput("stall_grant", 64'(req_ready), 64'b0100);
    expectGrant(2);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 4'hF, 1'b0);
      checkOutput("stall_req_ready", 64'(req_ready), 64'h0);
      checkOutput("stall_rsp_valid", 64'(rsp_valid), 64'h1);
      checkOutput("stall_rsp_id", 64'(rsp_id), 64'd2);
      checkOutput("stall_rsp_p", 64'(rsp_p), 64'h3FFF_FFFE_8000_0001);
    end
    // Drain and refill in the same cycle.
    applyStimulus(1'b1, 4'hF, 1'b1);
    checkOutput("refill_grant", 64'(req_ready), 64'b1000);
    expectGrant(3);
`ifdef KERNEL_MUL_RR_SCHED_STATS_EN
    checkOutput("stall_cnt", 64'(stall_cnt), 64'd5);
`endif

    // Reset while FULL and stalled discards the pending response.
    applyStimulus(1'b1, 4'hF, 1'b0);
    checkOutput("pre_rst_valid", 64'(rsp_valid), 64'h1);
    checkOutput("pre_rst_id", 64'(rsp_id), 64'd3);
    applyStimulus(1'b0, 4'hF, 1'b0);
    sb.delete();
    checkOutput("in_rst_req_ready", 64'(req_ready), 64'h0);
    applyStimulus(1'b1, 4'b1010, 1'b1);
    checkOutput("post_rst_valid", 64'(rsp_valid), 64'h0);
    checkOutput("post_rst_grant", 64'(req_ready), 64'b0010);
    expectGrant(1);
`ifdef KERNEL_MUL_RR_SCHED_STATS_EN
    checkOutput("post_rst_stall_cnt", 64'(stall_cnt), 64'h0);
`endif
    applyStimulus(1'b1, 4'h0, 1'b1);
    checkOutput("post_rst_rsp_valid", 64'(rsp_valid), 64'h1);
    applyStimulus(1'b1, 4'h0, 1'b1);
    checkOutput("final_empty", 64'(rsp_valid), 64'h0);
    checkOutput("sb_drained", 64'(sb.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
